jk_excite_driver: RTL and testbench
===================================

// Module: jk_excite_driver
// PURPOSE
//  Drive side of the J/K flip-flop interface: sequences a bank of WIDTH external JK flops through target states.
//  Takes target words over valid/ready, computes the minimal J/K excitation from live q, then reads q/qn back.
//  Flags any flop that missed its target. Owns the bank's active-low clear (flop_clr_n); bank shares clk.
// PARAMETERS
//  WIDTH       4   number of JK flops driven in parallel
//  CLR_CYCLES  2   cycles flop_clr_n held low after reset (>=1)
//  CNT_W       8   width of saturating error counter
// PORTS
//  clk          in   1      single clock; rising edge; also clocks the flop bank
//  clr          in   1      asynchronous, active-high reset
//  tgt_valid    in   1      target word offered
//  tgt_ready    out  1      driver accepts target (IDLE only)
//  tgt_data     in   WIDTH  desired next flop state
//  j            out  WIDTH  J excitation to flop bank (registered)
//  k            out  WIDTH  K excitation to flop bank (registered)
//  flop_clr_n   out  1      active-low clear to flop bank (registered)
//  q            in   WIDTH  flop bank q
//  qn           in   WIDTH  flop bank qn
//  done         out  1      one-cycle pulse: check of current target complete
//  miss_mask    out  WIDTH  per-bit mismatch of last check (held until next done)
//  err_count    out  CNT_W  saturating count of checks with any miss
//  err_clr      in   1      synchronous clear of err_count
// BEHAVIOUR
//  Reset (clr=1, async): state=INIT, j=k=0, flop_clr_n=0, tgt_ready=0, done=0, miss_mask=0, err_count=0.
//  FSM INIT -> IDLE -> DRIVE -> CHECK -> IDLE.
//   INIT: flop_clr_n=0 for CLR_CYCLES cycles after clr deasserts, then flop_clr_n<=1, -> IDLE.
//   IDLE: tgt_ready=1. Edge T0 with tgt_valid: latch tgt_data; j/k <= excitation(q, tgt_data); -> DRIVE.
//   DRIVE: bank captures j/k at edge T0+1; same edge j<=0, k<=0 (hold); -> CHECK.
//   CHECK: edge T0+2 compares q to latched target: miss_mask<=q^target; done<=1 for one cycle; -> IDLE.
//  Excitation per bit (don't-cares resolved to 0): 0->0 J0K0; 0->1 J1K0; 1->0 J0K1; 1->1 J0K0.
//   Never drives J=K=1 (no toggle use).
//  Latency accept->done = 2 edges; throughput one target per 3 cycles; tgt_ready low in DRIVE/CHECK.
//  err_count += 1 at CHECK edge when miss_mask!=0; saturates at 2^CNT_W-1, never wraps.
//  err_clr same edge as increment: clear wins (count=0).
//  tgt_valid in DRIVE/CHECK ignored; tgt_data must be held stable only on the accept edge.
//  clr mid-operation: immediate return to INIT; j/k forced 0, bank re-cleared, pending target dropped, no done.
// CONFIGURATION
//  JK_QN_CHECK_EN defined: CHECK also requires qn==~q; bit with qn!=~q marked in miss_mask even if q correct.
//  Undefined: qn port unused; only q compared.
// STRUCTURE
//  Package jk_drv_pkg: state enum {INIT,IDLE,DRIVE,CHECK}, excitation encoding constants.
//  Sub-module jk_excite_lut: combinational per-bit (q,target)->(j,k), replicated WIDTH times.
// TESTING (WIDTH=4, CLR_CYCLES=2, bench instantiates 4 real JK flops on clk, clr_n=flop_clr_n)
//  Reset release -> flop_clr_n low 2 cycles then high; tgt_ready rises; q=0000; err_count=0.
//  Target 1010 from q=0000 -> j=1010,k=0000 one cycle; done 2 edges after accept; q=1010; miss_mask=0000.
//  Target 0110 from q=1010 -> j=0100,k=1000; q=0110; miss=0; j=k=0 in CHECK.
//  Bench forces bit0 q stuck 0, target 0001 -> miss_mask=0001, err_count=1; 300 such -> saturates 255.
//  err_clr asserted on a failing CHECK edge -> err_count=0 next cycle.
//  clr pulsed during DRIVE -> no done; j=k=0; flop_clr_n low 2 cycles; next target processed normally.
//  JK_QN_CHECK_EN: bench forces qn[2]=q[2] -> miss_mask bit2 set; without macro -> miss_mask=0000.

Source files
------------

// File: rtl/jk_drv_pkg.sv
// Shared types and constants for the JK excitation driver: FSM state encoding
// and the {J,K} excitation codes.
package jk_drv_pkg;

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_DRIVE = 2'd2;
  localparam logic [1:0] ST_CHECK = 2'd3;

  typedef enum logic [1:0] {
    INIT  = ST_INIT,
    IDLE  = ST_IDLE,
    DRIVE = ST_DRIVE,
    CHECK = ST_CHECK
  } state_t;

  // {J,K} codes; the toggle code 2'b11 is deliberately never produced
  localparam logic [1:0] EXC_HOLD  = 2'b00;
  localparam logic [1:0] EXC_SET   = 2'b10;
  localparam logic [1:0] EXC_RESET = 2'b01;

endpackage

// File: rtl/jk_excite_driver_if.sv
// Target-word valid/ready handshake into the JK excitation driver.
interface jk_excite_driver_if #(
  parameter int unsigned WIDTH = 4
);
  logic             tgt_valid;
  logic             tgt_ready;
  logic [WIDTH-1:0] tgt_data;

  modport master (output tgt_valid, output tgt_data, input tgt_ready);
  modport slave  (input tgt_valid, input tgt_data, output tgt_ready);
endinterface

// File: rtl/jk_excite_lut.sv
// Per-bit minimal JK excitation: (current q, target) -> (j, k), don't-cares as 0.
module jk_excite_lut
  import jk_drv_pkg::*;
(
  input  logic q,
  input  logic tgt,
  output logic j,
  output logic k
);
  always_comb begin
    {j, k} = EXC_HOLD;
    case ({q, tgt})
      2'b01:   {j, k} = EXC_SET;
      2'b10:   {j, k} = EXC_RESET;
      default: {j, k} = EXC_HOLD;
    endcase
  end
endmodule

// File: rtl/jk_excite_driver.sv
// Drives a bank of WIDTH JK flops through target states and checks the result.
// Optional macro JK_QN_CHECK_EN: also flag bits whose qn is not ~q.
module jk_excite_driver
  import jk_drv_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned CLR_CYCLES = 2,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 clr,
  jk_excite_driver_if.slave    tgt,
  output logic [WIDTH-1:0]     j,
  output logic [WIDTH-1:0]     k,
  output logic                 flop_clr_n,
  input  logic [WIDTH-1:0]     q,
  input  logic [WIDTH-1:0]     qn,
  output logic                 done,
  output logic [WIDTH-1:0]     miss_mask,
  output logic [CNT_W-1:0]     err_count,
  input  logic                 err_clr
);
  localparam int unsigned CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);

  state_t           state;
  logic [CLR_W-1:0] clr_cnt;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] j_nxt;
  logic [WIDTH-1:0] k_nxt;
  logic [WIDTH-1:0] miss;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lut
    jk_excite_lut u_lut (
      .q   (q[i]),
      .tgt (tgt.tgt_data[i]),
      .j   (j_nxt[i]),
      .k   (k_nxt[i])
    );
  end

`ifdef JK_QN_CHECK_EN
  always_comb begin
    miss = (q ^ target) | ~(q ^ qn);
  end
`else
  logic unused_qn;
  assign unused_qn = ^qn;
  always_comb begin
    miss = q ^ target;
  end
`endif

  assign tgt.tgt_ready = (state == IDLE);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= INIT;
      clr_cnt    <= '0;
      target     <= '0;
      j          <= '0;
      k          <= '0;
      flop_clr_n <= 1'b0;
      done       <= 1'b0;
      miss_mask  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        INIT: begin
          if (clr_cnt == CLR_LAST) begin
            flop_clr_n <= 1'b1;
            state      <= IDLE;
          end else begin
            clr_cnt <= clr_cnt + CLR_W'(1);
          end
        end
        IDLE: begin
          if (tgt.tgt_valid) begin
            target <= tgt.tgt_data;
            j      <= j_nxt;
            k      <= k_nxt;
            state  <= DRIVE;
          end
        end
        DRIVE: begin
          // bank samples j/k on this edge; return to hold for the check cycle
          j     <= '0;
          k     <= '0;
          state <= CHECK;
        end
        CHECK: begin
          miss_mask <= miss;
          done      <= 1'b1;
          state     <= IDLE;
        end
        default: state <= INIT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= '0;
    end else if (state == CHECK && (|miss) && err_count != '1) begin
      err_count <= err_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_jk_excite_driver.sv
// Directed bench: the driver sequences four behavioural JK flops clocked on clk.
module tb_jk_excite_driver;
  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [3:0] j, k, q, qn, qf, miss_mask;
  logic       flop_clr_n, done, err_clr;
  logic [7:0] err_count;
  logic [3:0] stuck0 = 4'b0000;
  logic [3:0] qn_flip = 4'b0000;
  int unsigned checks = 0;
  int unsigned errors = 0;

  jk_excite_driver_if #(.WIDTH(4)) tif ();

  jk_excite_driver #(.WIDTH(4), .CLR_CYCLES(2), .CNT_W(8)) dut (
    .clk        (clk),
    .clr        (clr),
    .tgt        (tif),
    .j          (j),
    .k          (k),
    .flop_clr_n (flop_clr_n),
    .q          (q),
    .qn         (qn),
    .done       (done),
    .miss_mask  (miss_mask),
    .err_count  (err_count),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge flop_clr_n) begin
    if (!flop_clr_n) qf <= 4'b0000;
    else
      for (int i = 0; i < 4; i++)
        case ({j[i], k[i]})
          2'b10:   qf[i] <= 1'b1;
          2'b01:   qf[i] <= 1'b0;
          2'b11:   qf[i] <= ~qf[i];
          default: ;
        endcase
  end
  assign q  = qf & ~stuck0;
  assign qn = ~q ^ qn_flip;

  task automatic offer(input logic [3:0] t);
    @(negedge clk);
    tif.tgt_valid = 1'b1;
    tif.tgt_data  = t;
    @(posedge clk) #1;
    tif.tgt_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk) #1;
    if (j !== 4'b0 || k !== 4'b0) begin errors++; $display("FAIL reset_jk j=%b k=%b want 0000/0000", j, k); end
    checks++;
    if (flop_clr_n !== 1'b0 || tif.tgt_ready !== 1'b0) begin errors++; $display("FAIL reset_ctl clr_n=%b ready=%b want 0/0", flop_clr_n, tif.tgt_ready); end
    checks++;
    if (done !== 1'b0 || miss_mask !== 4'b0 || err_count !== 8'd0) begin errors++; $display("FAIL reset_stat done=%b miss=%b cnt=%0d want 0/0000/0", done, miss_mask, err_count); end
    checks++;
    @(negedge clk) clr = 1'b0;
    @(posedge clk) #1;
    if (flop_clr_n !== 1'b0 || tif.tgt_ready !== 1'b0) begin errors++; $display("FAIL init_hold clr_n=%b ready=%b want 0/0", flop_clr_n, tif.tgt_ready); end
    checks++;
    @(posedge clk) #1;
    if (flop_clr_n !== 1'b1 || tif.tgt_ready !== 1'b1) begin errors++; $display("FAIL init_done clr_n=%b ready=%b want 1/1", flop_clr_n, tif.tgt_ready); end
    checks++;
    if (q !== 4'b0000 || err_count !== 8'd0) begin errors++; $display("FAIL init_q q=%b cnt=%0d want 0000/0", q, err_count); end
    checks++;
  endtask

  task automatic test_set();
    offer(4'b1010);
    if (j !== 4'b1010 || k !== 4'b0000 || tif.tgt_ready !== 1'b0) begin errors++; $display("FAIL set_exc j=%b k=%b rdy=%b want 1010/0000/0", j, k, tif.tgt_ready); end
    checks++;
    @(posedge clk) #1;
    if (j !== 4'b0 || k !== 4'b0 || q !== 4'b1010 || done !== 1'b0) begin errors++; $display("FAIL set_drive j=%b k=%b q=%b done=%b want 0000/0000/1010/0", j, k, q, done); end
    checks++;
    @(posedge clk) #1;
    if (done !== 1'b1 || miss_mask !== 4'b0000 || tif.tgt_ready !== 1'b1) begin errors++; $display("FAIL set_done done=%b miss=%b rdy=%b want 1/0000/1", done, miss_mask, tif.tgt_ready); end
    checks++;
    @(posedge clk) #1;
    if (done !== 1'b0) begin errors++; $display("FAIL set_pulse done=%b want 0", done); end
    checks++;
  endtask

  task automatic test_mixed();
    offer(4'b0110);
    if (j !== 4'b0100 || k !== 4'b1000) begin errors++; $display("FAIL mix_exc j=%b k=%b want 0100/1000", j, k); end
    checks++;
    @(posedge clk) #1;
    if (j !== 4'b0 || k !== 4'b0 || q !== 4'b0110) begin errors++; $display("FAIL mix_check j=%b k=%b q=%b want 0000/0000/0110", j, k, q); end
    checks++;
    @(posedge clk) #1;
    if (done !== 1'b1 || miss_mask !== 4'b0000 || err_count !== 8'd0) begin errors++; $display("FAIL mix_done done=%b miss=%b cnt=%0d want 1/0000/0", done, miss_mask, err_count); end
    checks++;
  endtask

  task automatic test_stuck();
    stuck0 = 4'b0001;
    offer(4'b0001);
    if (j !== 4'b0001 || k !== 4'b0110) begin errors++; $display("FAIL stuck_exc j=%b k=%b want 0001/0110", j, k); end
    checks++;
    @(posedge clk); @(posedge clk) #1;
    if (done !== 1'b1 || miss_mask !== 4'b0001 || err_count !== 8'd1) begin errors++; $display("FAIL stuck_first done=%b miss=%b cnt=%0d want 1/0001/1", done, miss_mask, err_count); end
    checks++;
    for (int n = 2; n <= 300; n++) begin
      offer(4'b0001);
      @(posedge clk); @(posedge clk) #1;
      if (n == 255 || n == 256 || n == 300) begin
        if (err_count !== 8'd255) begin errors++; $display("FAIL stuck_sat n=%0d cnt=%0d want 255", n, err_count); end
        checks++;
      end
      if (n == 254) begin
        if (err_count !== 8'd254) begin errors++; $display("FAIL stuck_254 cnt=%0d want 254", err_count); end
        checks++;
      end
    end
  endtask

  task automatic test_err_clr();
    offer(4'b0001);
    @(posedge clk) #1;
    err_clr = 1'b1;
    @(posedge clk) #1;
    err_clr = 1'b0;
    if (done !== 1'b1 || miss_mask !== 4'b0001 || err_count !== 8'd0) begin errors++; $display("FAIL errclr done=%b miss=%b cnt=%0d want 1/0001/0", done, miss_mask, err_count); end
    checks++;
    @(posedge clk) #1;
    if (err_count !== 8'd0) begin errors++; $display("FAIL errclr_hold cnt=%0d want 0", err_count); end
    checks++;
  endtask

  task automatic test_clr_mid();
    @(negedge clk) stuck0 = 4'b0000;
    offer(4'b1000);
    if (j !== 4'b1000 || k !== 4'b0001) begin errors++; $display("FAIL mid_exc j=%b k=%b want 1000/0001", j, k); end
    checks++;
    clr = 1'b1;
    #1;
    if (j !== 4'b0 || k !== 4'b0 || flop_clr_n !== 1'b0 || q !== 4'b0000) begin errors++; $display("FAIL mid_clr j=%b k=%b clr_n=%b q=%b want 0000/0000/0/0000", j, k, flop_clr_n, q); end
    checks++;
    @(negedge clk) clr = 1'b0;
    @(posedge clk) #1;
    if (flop_clr_n !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mid_init1 clr_n=%b done=%b want 0/0", flop_clr_n, done); end
    checks++;
    @(posedge clk) #1;
    if (flop_clr_n !== 1'b1 || done !== 1'b0 || tif.tgt_ready !== 1'b1 || err_count !== 8'd0) begin errors++; $display("FAIL mid_init2 clr_n=%b done=%b rdy=%b cnt=%0d want 1/0/1/0", flop_clr_n, done, tif.tgt_ready, err_count); end
    checks++;
    offer(4'b0011);
    if (j !== 4'b0011 || k !== 4'b0000) begin errors++; $display("FAIL mid_next_exc j=%b k=%b want 0011/0000", j, k); end
    checks++;
    @(posedge clk); @(posedge clk) #1;
    if (done !== 1'b1 || miss_mask !== 4'b0000 || q !== 4'b0011) begin errors++; $display("FAIL mid_next done=%b miss=%b q=%b want 1/0000/0011", done, miss_mask, q); end
    checks++;
  endtask

  task automatic test_qn();
    logic [3:0] exp_miss;
    logic [7:0] exp_cnt;
`ifdef JK_QN_CHECK_EN
    exp_miss = 4'b0100;
    exp_cnt  = 8'd1;
`else
    exp_miss = 4'b0000;
    exp_cnt  = 8'd0;
`endif
    qn_flip = 4'b0100;
    offer(4'b0111);
    if (j !== 4'b0100 || k !== 4'b0000) begin errors++; $display("FAIL qn_exc j=%b k=%b want 0100/0000", j, k); end
    checks++;
    @(posedge clk); @(posedge clk) #1;
    if (done !== 1'b1 || q !== 4'b0111 || miss_mask !== exp_miss || err_count !== exp_cnt) begin errors++; $display("FAIL qn_check done=%b q=%b miss=%b cnt=%0d want 1/0111/%b/%0d", done, q, miss_mask, err_count, exp_miss, exp_cnt); end
    checks++;
    qn_flip = 4'b0000;
  endtask

  initial begin
    tif.tgt_valid = 1'b0;
    tif.tgt_data  = 4'b0000;
    err_clr = 1'b0;
    test_reset();
    test_set();
    test_mixed();
    test_stuck();
    test_err_clr();
    test_clr_mid();
    test_qn();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
